// File: rtl/obi_model_pkg.sv
// Shared types and helpers for the OBI slave environment model.
//
// Contents:
//   ADDR_W, DATA_W, BE_W   default bus widths
//   obi_req_t              {addr, we, be, wdata} request record
//   byte_merge()           byte-enable merge of a new word into an old one
package obi_model_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_pend_fifo.sv
// Generic push/pop FIFO with occupancy count and combinational head.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Pointers wrap explicitly, so any Depth >= 1 works.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write request and entry
//   pop_i           retire the head entry (ignored when empty)
//   head_o          oldest entry (undefined content when empty)
//   count_o         number of stored entries
module obi_pend_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != DepthC) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/obi_resp_model.sv
// OBI slave environment model for one core memory port.
// Free rand_* proposals from the harness are gated so only legal OBI
// responses reach the core: bounded outstanding depth, in-order responses,
// a response forced after MAX_LAT cycles at the head, and a sticky monitor
// flag for requests that change while waiting for grant.
//
// Optional feature (macro OBI_RESP_MODEL_MEM_EN): a MEM_WORDS x DATA_W
// backing memory updated at response time; rand_rdata_i is then ignored.
// The memory path merges bytes with obi_model_pkg::byte_merge, so it
// assumes DATA_W matches obi_model_pkg::DATA_W.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_i, addr_i, we_i, be_i, wdata_i OBI request from the core
//   gnt_o, rvalid_o, rdata_o           OBI grant / response to the core
//   rand_gnt_i, rand_rvalid_i,
//   rand_rdata_i                       unconstrained harness proposals
//   pending_o                          granted-but-unanswered count
//   resp_we_o, resp_addr_o             head transaction (valid with rvalid_o)
//   proto_err_o                        sticky request-stability violation
module obi_resp_model #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned MAX_LAT         = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MEM_WORDS       = 16,
    localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    input  logic                rand_gnt_i,
    input  logic                rand_rvalid_i,
    input  logic [DATA_W-1:0]   rand_rdata_i,
    output logic [CntW-1:0]     pending_o,
    output logic                resp_we_o,
    output logic [ADDR_W-1:0]   resp_addr_o,
    output logic                proto_err_o
);

    localparam int unsigned     BeW     = DATA_W / 8;
    localparam int unsigned     EntW    = 1 + ADDR_W + BeW + DATA_W;
    localparam int unsigned     AgeW    = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam logic [AgeW-1:0] MaxLatA = AgeW'(MAX_LAT);
    localparam logic [CntW-1:0] MaxOutC = CntW'(MAX_OUTSTANDING);

    // Entry layout: {we, addr, be, wdata}
    logic [EntW-1:0]   req_ent;
    logic [EntW-1:0]   head_ent;
    logic [CntW-1:0]   count;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [BeW-1:0]    head_be;
    logic [DATA_W-1:0] head_wdata;

    logic [AgeW-1:0]   age_q, age_d;
    logic              lat_expired;

    assign req_ent = {we_i, addr_i, be_i, wdata_i};

    // ------------------------------------------------------------------
    // Pending transactions
    // ------------------------------------------------------------------
    obi_pend_fifo #(
        .Width (EntW),
        .Depth (MAX_OUTSTANDING)
    ) u_pend_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (gnt_o),
        .data_i  (req_ent),
        .pop_i   (rvalid_o),
        .head_o  (head_ent),
        .count_o (count)
    );

    assign head_we    = head_ent[EntW-1];
    assign head_addr  = head_ent[EntW-2 -: ADDR_W];
    assign head_be    = head_ent[DATA_W +: BeW];
    assign head_wdata = head_ent[DATA_W-1:0];

    assign lat_expired = (MAX_LAT != 0) && (age_q >= MaxLatA);

    // count is registered, so a response can never land in its grant cycle.
    assign rvalid_o = rst_ni & (count != '0) & (rand_rvalid_i | lat_expired);
    // A full FIFO may still grant when the head retires this cycle.
    assign gnt_o    = rst_ni & req_i & rand_gnt_i & ((count < MaxOutC) | rvalid_o);

    // Age measures time spent at the head, so it restarts on every pop.
    always_comb begin
        age_d = age_q;
        if ((count == '0) || rvalid_o) begin
            age_d = '0;
        end else if (age_q < MaxLatA) begin
            age_d = age_q + AgeW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign pending_o   = count;
    assign resp_we_o   = head_we;
    assign resp_addr_o = head_addr;

    // ------------------------------------------------------------------
    // Request-stability monitor
    // ------------------------------------------------------------------
    logic            held;
    logic            held_valid;
    logic [EntW-1:0] held_ent;
    logic            held_cnt;
    logic            violation;
    logic            proto_err_q, proto_err_d;

    assign held = req_i & ~gnt_o;

    // Depth-1 FIFO: an entry lives exactly one cycle, then is compared.
    obi_pend_fifo #(
        .Width (EntW),
        .Depth (1)
    ) u_held_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (held),
        .data_i  (req_ent),
        .pop_i   (held_valid),
        .head_o  (held_ent),
        .count_o (held_cnt)
    );

    assign held_valid = held_cnt;

    // wdata only matters for writes; we changing is already a violation.
    always_comb begin
        violation = 1'b0;
        if (held_valid) begin
            violation = ~req_i
                      | (addr_i != held_ent[EntW-2 -: ADDR_W])
                      | (we_i   != held_ent[EntW-1])
                      | (be_i   != held_ent[DATA_W +: BeW])
                      | (we_i & (wdata_i != held_ent[DATA_W-1:0]));
        end
    end

    assign proto_err_d = proto_err_q | violation;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err_o = proto_err_q;

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
`ifdef OBI_RESP_MODEL_MEM_EN
    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [IdxW-1:0]   head_idx;
    logic [DATA_W-1:0] unused_rand_rdata;

    assign head_idx          = head_addr[IdxW+1:2];
    assign unused_rand_rdata = rand_rdata_i;

    // Writes land at response time, so later reads of the word see them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (rvalid_o && head_we) begin
            mem_q[head_idx] <= obi_model_pkg::byte_merge(mem_q[head_idx], head_wdata, head_be);
        end
    end

    assign rdata_o = mem_q[head_idx];
`else
    logic unused_head;

    assign unused_head = ^{head_be, head_wdata, 32'(MEM_WORDS)};
    assign rdata_o     = rand_rdata_i;
`endif

endmodule

// File: tb/tb_obi_resp_model.sv
// Randomised + directed bench for obi_resp_model with a queue-based model.
module tb_obi_resp_model;

    localparam int unsigned MO = 2;
    localparam int unsigned ML = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, gnt, rvalid, resp_we, proto_err;
    logic        rand_gnt, rand_rvalid;
    logic [31:0] addr, wdata, rdata, rand_rdata, resp_addr;
    logic [3:0]  be;
    logic [1:0]  pending;

    // staged inputs, applied at the next falling edge
    logic        s_rst_n, s_req, s_we, s_rg, s_rv;
    logic [31:0] s_addr, s_wdata, s_rd;
    logic [3:0]  s_be;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    obi_resp_model #(
        .MAX_OUTSTANDING (MO),
        .MAX_LAT         (ML),
        .ADDR_W          (32),
        .DATA_W          (32),
        .MEM_WORDS       (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .addr_i        (addr),
        .we_i          (we),
        .be_i          (be),
        .wdata_i       (wdata),
        .gnt_o         (gnt),
        .rvalid_o      (rvalid),
        .rdata_o       (rdata),
        .rand_gnt_i    (rand_gnt),
        .rand_rvalid_i (rand_rvalid),
        .rand_rdata_i  (rand_rdata),
        .pending_o     (pending),
        .resp_we_o     (resp_we),
        .resp_addr_o   (resp_addr),
        .proto_err_o   (proto_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t        mq[$];
    int          m_age;
    bit          m_err;
    bit          m_held_v;
    txn_t        m_held;
    logic [31:0] m_mem [16];

    task automatic model_reset();
        mq.delete();
        m_age    = 0;
        m_err    = 0;
        m_held_v = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Compare process: every cycle, after inputs settle, before the rising edge.
    always @(negedge clk) begin
        bit          e_rv, e_g, viol;
        txn_t        cur, h;
        logic [31:0] e_rd;
        int          sz;
        #2;
        if (!rst_n) begin
            model_reset();
            check("rst_gnt", gnt, 0);
            check("rst_rvalid", rvalid, 0);
            check("rst_pending", pending, 0);
            check("rst_err", proto_err, 0);
        end else begin
            sz   = mq.size();
            e_rv = (sz != 0) && (rand_rvalid || (ML != 0 && m_age >= ML));
            e_g  = req && rand_gnt && (sz < MO || e_rv);
            cur  = '{we: we, addr: addr, be: be, wdata: wdata};
            viol = m_held_v && (!req || addr != m_held.addr || we != m_held.we ||
                                be != m_held.be || (we && wdata != m_held.wdata));
            check("gnt", gnt, e_g);
            check("rvalid", rvalid, e_rv);
            check("pending", pending, sz);
            check("proto_err", proto_err, m_err);
            if (e_rv) begin
                h = mq[0];
`ifdef OBI_RESP_MODEL_MEM_EN
                e_rd = m_mem[h.addr[5:2]];
`else
                e_rd = rand_rdata;
`endif
                check("resp_we", resp_we, h.we);
                check("resp_addr", resp_addr, h.addr);
                check("rdata", rdata, e_rd);
            end
            // state update for the coming rising edge
            if (e_rv) begin
                h = mq.pop_front();
                if (h.we) m_mem[h.addr[5:2]] = merge(m_mem[h.addr[5:2]], h.wdata, h.be);
            end
            if (e_g) mq.push_back(cur);
            m_age    = (sz == 0 || e_rv) ? 0 : ((m_age + 1 > ML) ? ML : m_age + 1);
            m_err    = m_err || viol;
            m_held_v = req && !e_g;
            m_held   = cur;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        rst_n       = s_rst_n;
        req         = s_req;
        addr        = s_addr;
        we          = s_we;
        be          = s_be;
        wdata       = s_wdata;
        rand_gnt    = s_rg;
        rand_rvalid = s_rv;
        rand_rdata  = s_rd;
        #3;
    endtask

    task automatic set_req(input logic r, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
        s_req = r; s_addr = a; s_we = w; s_be = b; s_wdata = d;
    endtask

    task automatic set_rand(input logic g, input logic v, input logic [31:0] d);
        s_rg = g; s_rv = v; s_rd = d;
    endtask

    task automatic do_reset();
        s_rst_n = 0;
        set_req(1, 32'h0, 0, 4'hF, 32'h0);
        set_rand(1, 1, 32'h0);
        step();
        check("lit_rst_gnt", gnt, 0);
        check("lit_rst_rvalid", rvalid, 0);
        step();
        check("lit_rst_pending", pending, 0);
        s_rst_n = 1;
        set_req(0, 32'h0, 0, 4'hF, 32'h0);
        set_rand(0, 0, 32'h0);
    endtask

    bit prev_held;

    initial begin
        rst_n = 0; req = 0; addr = 0; we = 0; be = 0; wdata = 0;
        rand_gnt = 0; rand_rvalid = 0; rand_rdata = 0;
        do_reset();

        // fill to MAX_OUTSTANDING, then stall
        set_req(1, 32'h1000_0010, 0, 4'hF, 32'h0);
        set_rand(1, 0, 32'h0);
        step(); check("lit_fill_g0", gnt, 1); check("lit_fill_p0", pending, 0);
        step(); check("lit_fill_g1", gnt, 1); check("lit_fill_p1", pending, 1);
        step(); check("lit_fill_g2", gnt, 0); check("lit_fill_p2", pending, 2);
        // full with simultaneous retire
        set_rand(1, 1, 32'h1234_5678);
        step();
        check("lit_full_rv", rvalid, 1); check("lit_full_g", gnt, 1);
        check("lit_full_addr", resp_addr, 32'h1000_0010);
        set_req(0, 32'h0, 0, 4'hF, 32'h0);
        set_rand(0, 0, 32'h0);
        step(); check("lit_full_p", pending, 2);
        set_rand(0, 1, 32'h0);
        step(); step();
        set_rand(0, 0, 32'h0);
        step(); check("lit_drain_p", pending, 0);

        // empty FIFO ignores rand_rvalid; response possible one cycle after grant
        set_req(1, 32'h2000_0040, 0, 4'hF, 32'h0);
        set_rand(1, 1, 32'hCAFE_0001);
        step(); check("lit_t_rv", rvalid, 0); check("lit_t_g", gnt, 1);
        set_req(0, 32'h0, 0, 4'hF, 32'h0);
        step(); check("lit_t1_rv", rvalid, 1);

        // bounded latency
        set_req(1, 32'h2000_0080, 0, 4'hF, 32'h0);
        set_rand(1, 0, 32'h0);
        step(); check("lit_lat_g", gnt, 1);
        set_req(0, 32'h0, 0, 4'hF, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("lit_lat_rv%0d", k), rvalid, (k == 5));
            if (k == 5) check("lit_lat_addr", resp_addr, 32'h2000_0080);
        end
        check("lit_lat_p", pending, 0);

`ifdef OBI_RESP_MODEL_MEM_EN
        set_req(1, 32'h8, 1, 4'b0011, 32'hDEAD_BEEF);
        set_rand(1, 0, 32'hFFFF_FFFF);
        step();
        set_req(1, 32'h8, 0, 4'hF, 32'h0);
        set_rand(1, 1, 32'hFFFF_FFFF);
        step();
        set_req(0, 32'h0, 0, 4'hF, 32'h0);
        step(); check("lit_mem_rv", rvalid, 1); check("lit_mem_rd", rdata, 32'h0000_BEEF);
        set_req(1, 32'h8, 0, 4'hF, 32'h0);
        set_rand(1, 0, 32'h0);
        step();
        do_reset();
        check("lit_mem_rst_p", pending, 0);
        set_req(1, 32'h8, 0, 4'hF, 32'h0);
        set_rand(1, 0, 32'h0);
        step();
        set_req(0, 32'h0, 0, 4'hF, 32'h0);
        set_rand(0, 1, 32'hFFFF_FFFF);
        step(); check("lit_mem_clr", rdata, 32'h0);
        set_rand(0, 0, 32'h0);
        step();
`endif

        // randomised traffic, mostly protocol-abiding
        prev_held = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                prev_held = 0;
                continue;
            end
            if (!(prev_held && $urandom_range(0, 31) != 0)) begin
                set_req($urandom_range(0, 9) < 7, 32'h1A00_0000 | (32'($urandom_range(0, 15)) << 2),
                        1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            end
            set_rand(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom);
            step();
            prev_held = req && !gnt;
        end

        // request changes while held
        do_reset();
        set_req(1, 32'h1A00_0080, 0, 4'hF, 32'h0);
        set_rand(0, 0, 32'h0);
        step(); check("lit_held_g", gnt, 0); check("lit_err0", proto_err, 0);
        set_req(1, 32'h1A00_0084, 0, 4'hF, 32'h0);
        step(); check("lit_err_same", proto_err, 0);
        set_req(0, 32'h0, 0, 4'hF, 32'h0);
        step(); check("lit_err1", proto_err, 1);
        for (int k = 0; k < 6; k++) begin
            set_req(1, 32'h1A00_0000 | (32'(k) << 2), 0, 4'hF, 32'h0);
            set_rand(1, 1, 32'h0);
            step();
        end
        check("lit_err_sticky", proto_err, 1);
        do_reset();
        step(); check("lit_err_clr", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
